ps2_key_decoder: RTL



---
 rtl/ps2_key_decoder_if.sv | 10 +
 rtl/ps2_key_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pin and decoded-key bundle between board pins, decoder and keyboard consumer.
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_error;

  modport master (output ps2_clk, output ps2_data, input ps2_key, input frame_error);
  modport slave  (input ps2_clk, input ps2_data, output ps2_key, output frame_error);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 deframer folding E0/F0/E1 prefixes into {toggle, pressed, extended, code}.
// Define PS2_TYPEMATIC_FILTER_EN to suppress repeated make events of keys already held.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input logic               clk,
  input logic               reset,
  ps2_key_decoder_if.slave  ps2
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  logic          timeout;

  state_t        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic          ext_q, brk_q;
  logic [2:0]    skip_q;
  logic [10:0]   key_q;
  logic          err_q;
  logic [10:0]   key_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0]  held_q;
  logic [8:0]    hidx;
  assign hidx = {ext_q, shreg_q};
`endif

  // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FLT_LAST) filt_d = clk_s2_q;
      else                    fcnt_d = fcnt_q + FW'(1);
    end
  end

  assign fall    = filt_q & ~filt_d;
  assign timeout = (state_q != S_IDLE) && (to_cnt_q == TO_LAST);
  assign key_d   = {~key_q[10], ~brk_q, ext_q, shreg_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      to_cnt_q  <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      skip_q    <= '0;
      key_q     <= '0;
      err_q     <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_q    <= '0;
`endif
    end else begin
      clk_s1_q <= ps2.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2.ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      err_q    <= 1'b0;

      if (state_q == S_IDLE || fall) to_cnt_q <= '0;
      else                           to_cnt_q <= to_cnt_q + TW'(1);

      // Expiry takes priority over a coincident edge.
      if (timeout) begin
        state_q  <= S_IDLE;
        err_q    <= 1'b1;
        ext_q    <= 1'b0;
        brk_q    <= 1'b0;
        to_cnt_q <= '0;
      end else if (fall) begin
        case (state_q)
          S_IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end else begin
              err_q <= 1'b1;
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
          end
          S_DATA: begin
            shreg_q   <= {dat_s2_q, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (!dat_s2_q || !(^{shreg_q, par_q})) begin
              err_q <= 1'b1;
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end else if (skip_q != 3'd0) begin
              skip_q <= skip_q - 3'd1;
            end else if (shreg_q == 8'hE1) begin
              // Pause sends seven more bytes that carry no key information.
              skip_q <= 3'd7;
              ext_q  <= 1'b0;
              brk_q  <= 1'b0;
            end else if (shreg_q == 8'hE0) begin
              ext_q <= 1'b1;
            end else if (shreg_q == 8'hF0) begin
              brk_q <= 1'b1;
            end else begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
              if (brk_q) begin
                held_q[hidx] <= 1'b0;
                key_q        <= key_d;
              end else if (!held_q[hidx]) begin
                held_q[hidx] <= 1'b1;
                key_q        <= key_d;
              end
`else
              key_q <= key_d;
`endif
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ps2.ps2_key     = key_q;
  assign ps2.frame_error = err_q;

endmodule
